// File: rtl/pifo_stfq_ranker_pkg.sv
// Shared types and constants for the STFQ ranker feeding the 4-entry PIFO.
// VT_W is the virtual-time / tag width used by tag_ge and the ranker datapath.
package pifo_pkg;
    localparam int RANK_W     = 4;
    localparam int QUEUE_SIZE = 4;
    localparam int RANK_MAX   = 15;
    localparam int VT_W       = 12;

    typedef enum logic [1:0] {IDLE, CALC, PUSH} state_t;

    // Modular a >= b: valid while both tags lie within half the tag space.
    function automatic logic tag_ge(input logic [VT_W-1:0] a, input logic [VT_W-1:0] b);
        logic [VT_W-1:0] diff;
        diff = a - b;
        return ~diff[VT_W-1];
    endfunction
endpackage

// File: rtl/pifo_stfq_ranker_if.sv
// Descriptor input and PIFO-side handshake bundle for pifo_stfq_ranker.
interface pifo_stfq_ranker_if
    import pifo_pkg::*;
#(
    parameter int FLOW_W = 2,
    parameter int LEN_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [FLOW_W-1:0] in_flow;
    logic [LEN_W-1:0]  in_len;
    logic              pifo_full;
    logic              pifo_pop;
    logic              deq_valid;
    logic [RANK_W-1:0] deq_priority;
    logic              push;
    logic [RANK_W-1:0] priority_in;

    modport master (
        output in_valid, in_flow, in_len, pifo_full, pifo_pop, deq_valid, deq_priority,
        input  in_ready, push, priority_in
    );

    modport slave (
        input  in_valid, in_flow, in_len, pifo_full, pifo_pop, deq_valid, deq_priority,
        output in_ready, push, priority_in
    );
endinterface

// File: rtl/pifo_tag_table.sv
// Per-flow finish-tag register file: one combinational read, one write, async clear.
module pifo_tag_table #(
    parameter int NUM_FLOWS = 4,
    parameter int FLOW_W    = 2,
    parameter int TAG_W     = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOW_W-1:0] rd_addr,
    output logic [TAG_W-1:0]  rd_data,
    input  logic              we,
    input  logic [FLOW_W-1:0] wr_addr,
    input  logic [TAG_W-1:0]  wr_data
);
    logic [TAG_W-1:0] tags [NUM_FLOWS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_FLOWS; i++) tags[i] <= '0;
        end else if (we) begin
            tags[wr_addr] <= wr_data;
        end
    end

    assign rd_data = tags[rd_addr];
endmodule

// File: rtl/pifo_stfq_ranker.sv
// STFQ start-tag ranker driving PIFO push/priority_in; virtual time follows PIFO pops.
// Optional stat_push_cnt/stat_sat_cnt outputs when PIFO_RANKER_STATS_EN is defined.
module pifo_stfq_ranker
    import pifo_pkg::*;
#(
    parameter int NUM_FLOWS  = 4,
    parameter int FLOW_W     = 2,
    parameter int LEN_W      = 8,
    parameter int COST_SHIFT = 4
) (
    input  logic clk,
    input  logic reset,
    pifo_stfq_ranker_if.slave bus
`ifdef PIFO_RANKER_STATS_EN
    ,
    output logic [15:0] stat_push_cnt,
    output logic [15:0] stat_sat_cnt
`endif
);
    state_t            state;
    logic [FLOW_W-1:0] flow_q;
    logic [VT_W-1:0]   cost_q;
    logic [VT_W-1:0]   vtime;
    logic              in_ready_q;
    logic              push_q;
    logic [RANK_W-1:0] prio_q;

    logic [VT_W-1:0]   fin_rd;
    logic [VT_W-1:0]   start;
    logic [VT_W-1:0]   span;
    logic [VT_W-1:0]   finish_nxt;
    logic [VT_W-1:0]   in_cost;
    logic [RANK_W-1:0] rank;
    logic [RANK_W-1:0] deq_cost;
    logic              sat;
    logic              push_fire;

    pifo_tag_table #(
        .NUM_FLOWS (NUM_FLOWS),
        .FLOW_W    (FLOW_W),
        .TAG_W     (VT_W)
    ) u_tags (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (flow_q),
        .rd_data (fin_rd),
        .we      (state == CALC),
        .wr_addr (flow_q),
        .wr_data (finish_nxt)
    );

    always_comb begin
        in_cost = VT_W'(bus.in_len >> COST_SHIFT);
        if (in_cost == '0) in_cost = VT_W'(1);
        start      = tag_ge(fin_rd, vtime) ? fin_rd : vtime;
        span       = start - vtime;
        sat        = span > VT_W'(RANK_MAX);
        rank       = sat ? RANK_W'(RANK_MAX) : span[RANK_W-1:0];
        // Finish tag advances from the unsaturated start even when rank clips.
        finish_nxt = start + cost_q;
        deq_cost   = RANK_W'(RANK_MAX) - bus.deq_priority;
        push_fire  = (state == PUSH) && !bus.pifo_full && !bus.pifo_pop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            flow_q     <= '0;
            cost_q     <= '0;
            vtime      <= '0;
            in_ready_q <= 1'b0;
            push_q     <= 1'b0;
            prio_q     <= '0;
        end else begin
            push_q <= 1'b0;
            if (bus.deq_valid) vtime <= vtime + VT_W'(deq_cost);
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        flow_q     <= bus.in_flow;
                        cost_q     <= in_cost;
                        in_ready_q <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    prio_q <= RANK_W'(RANK_MAX) - rank;
                    state  <= PUSH;
                end
                PUSH: begin
                    if (push_fire) begin
                        push_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIFO_RANKER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_push_cnt <= '0;
            stat_sat_cnt  <= '0;
        end else begin
            if (push_fire && stat_push_cnt != '1) stat_push_cnt <= stat_push_cnt + 16'd1;
            if (state == CALC && sat && stat_sat_cnt != '1) stat_sat_cnt <= stat_sat_cnt + 16'd1;
        end
    end
`endif

    assign bus.in_ready    = in_ready_q;
    assign bus.push        = push_q;
    assign bus.priority_in = prio_q;
endmodule

// File: tb/tb_pifo_stfq_ranker.sv
// Directed self-checking bench for pifo_stfq_ranker (stats checked when PIFO_RANKER_STATS_EN is defined).
module tb_pifo_stfq_ranker;
    import pifo_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    pifo_stfq_ranker_if #(.FLOW_W(2), .LEN_W(8)) bus ();

`ifdef PIFO_RANKER_STATS_EN
    logic [15:0] stat_push_cnt;
    logic [15:0] stat_sat_cnt;
`endif

    pifo_stfq_ranker #(
        .NUM_FLOWS  (4),
        .FLOW_W     (2),
        .LEN_W      (8),
        .COST_SHIFT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PIFO_RANKER_STATS_EN
        ,
        .stat_push_cnt (stat_push_cnt),
        .stat_sat_cnt  (stat_sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic accept(input logic [1:0] f, input logic [7:0] l);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_flow  = f;
        bus.in_len   = l;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_push(input string tag, input logic [3:0] exp_pri, input int exp_lat);
        int n;
        n = 0;
        while (bus.push !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_pri"}, 32'(bus.priority_in), 32'(exp_pri));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(bus.push), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_flow      = '0;
        bus.in_len       = '0;
        bus.pifo_full    = 1'b0;
        bus.pifo_pop     = 1'b0;
        bus.deq_valid    = 1'b0;
        bus.deq_priority = '0;

        #12;
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_push", 32'(bus.push), 32'd0);
        check("rst_pri", 32'(bus.priority_in), 32'd0);
        release_reset();

        // flow0 len64: start 0, rank 0, finish0 = 4
        accept(2'd0, 8'd64);
        check("t1_rdy_a", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        check("t1_rdy_b", 32'(bus.in_ready), 32'd0);
        check("t1_nopush", 32'(bus.push), 32'd0);
        wait_push("t1", 4'd15, 1);

        // flow0 len32: start 4, rank 4, finish0 = 6
        accept(2'd0, 8'd32);
        wait_push("t2", 4'd11, 2);

        // pop at priority 11 advances vtime to 4
        bus.deq_valid    = 1'b1;
        bus.deq_priority = 4'd11;
        @(posedge clk); #1;
        bus.deq_valid    = 1'b0;

        accept(2'd1, 8'd16);              // start = vtime 4, rank 0
        wait_push("t3", 4'd15, 2);
        accept(2'd0, 8'd16);              // start 6, rank 2, finish0 = 7
        wait_push("t4", 4'd13, 2);

        // full stall: flow3 len0 -> cost forced to 1, start 4, priority 15
        bus.pifo_full = 1'b1;
        accept(2'd3, 8'd0);
        repeat (5) begin
            @(posedge clk); #1;
            check("stall_push", 32'(bus.push), 32'd0);
            check("stall_rdy", 32'(bus.in_ready), 32'd0);
        end
        check("stall_pri", 32'(bus.priority_in), 32'd15);
        bus.pifo_full = 1'b0;
        wait_push("t5", 4'd15, 1);

        // pop collision defers push; flow3 start 5, rank 1
        accept(2'd3, 8'd0);
        bus.pifo_pop = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pop_push", 32'(bus.push), 32'd0);
        bus.pifo_pop = 1'b0;
        wait_push("t6", 4'd14, 1);

        // reset while push is high
        accept(2'd2, 8'd16);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rp_push_hi", 32'(bus.push), 32'd1);
        #2 reset = 1'b0;
        #1 check("rp_push_lo", 32'(bus.push), 32'd0);
        release_reset();

        // reset while stalled in PUSH with the PIFO full
        bus.pifo_full = 1'b1;
        accept(2'd0, 8'd16);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        check("rf_push", 32'(bus.push), 32'd0);
        check("rf_ready", 32'(bus.in_ready), 32'd0);
        check("rf_pri", 32'(bus.priority_in), 32'd0);
        bus.pifo_full = 1'b0;
        release_reset();

        // cleared tags and vtime: flow0 start 0 (else start 7, priority 12)
        accept(2'd0, 8'd16);
        wait_push("t7", 4'd15, 2);

        // flow2 len80 x5: starts 0,5,10,15,20 -> last rank saturates
        accept(2'd2, 8'd80); wait_push("s0", 4'd15, 2);
        accept(2'd2, 8'd80); wait_push("s1", 4'd10, 2);
        accept(2'd2, 8'd80); wait_push("s2", 4'd5, 2);
        accept(2'd2, 8'd80); wait_push("s3", 4'd0, 2);
        accept(2'd2, 8'd80); wait_push("s4", 4'd0, 2);

        // pop during CALC: CALC sees vtime 0, then vtime becomes 15
        accept(2'd1, 8'd16);
        bus.deq_valid    = 1'b1;
        bus.deq_priority = 4'd0;
        @(posedge clk); #1;
        bus.deq_valid    = 1'b0;
        wait_push("dc", 4'd15, 1);
        accept(2'd2, 8'd16);              // finish2 25 vs vtime 15: rank 10
        wait_push("dv", 4'd5, 2);

`ifdef PIFO_RANKER_STATS_EN
        check("stat_push", 32'(stat_push_cnt), 32'd8);
        check("stat_sat", 32'(stat_sat_cnt), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pifo_stfq_ranker.md
Name: pifo_stfq_ranker

Overview:
- Upstream feeder for the 4-entry PIFO priority queue.
- Accepts packet descriptors (flow id, length) and computes a start-time fair queuing (STFQ) start tag from per-flow finish tags and a global virtual time.
- Converts each start tag to a 4-bit PIFO priority and drives the PIFO push/priority_in interface, honouring PIFO full and push/pop collision rules.
- Virtual time advances from the priorities the PIFO pops.

Parameters:
NUM_FLOWS, 4, number of flows tracked
FLOW_W, 2, flow id width (log2 NUM_FLOWS)
LEN_W, 8, packet length width
VT_W, 12, virtual time / tag width, modular arithmetic
COST_SHIFT, 4, cost = max(1, len >> COST_SHIFT)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid && in_ready
in_flow  in  FLOW_W  flow id
in_len  in  LEN_W  packet length
pifo_full  in  1  PIFO full flag
pifo_pop  in  1  pop request currently driven to the PIFO (observed only)
deq_valid  in  1  a PIFO pop completed this cycle
deq_priority  in  4  PIFO priority_out for that pop
push  out  1  PIFO push strobe
priority_in  out  4  PIFO priority; higher value is served first

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; vtime=0; all finish tags=0; push=0; priority_in=0; in_ready=0 while in reset, 1 in the first cycle after release.
- FSM states and transitions:
  - IDLE: in_ready=1. On accept, latch flow and length, go to CALC.
  - CALC: in_ready=0.
    - start = (finish[flow] − vtime)[VT_W−1] ? vtime : finish[flow] (modular max).
    - rank = min(start − vtime, 15).
    - finish[flow] <= start + cost.
    - Latch priority = 15 − rank.
    - Go to PUSH.
  - PUSH: in_ready=0. If !pifo_full && !pifo_pop: push=1 for exactly this cycle, go to IDLE. Otherwise hold push=0 and stay in PUSH (stall, no timeout).
- push is registered:
  - push asserted one cycle after entering PUSH. Counted in that convention: accept edge t, CALC cycle t+1, push high in cycle t+2 at the earliest.
  - priority_in holds its value until the next CALC.
  - Minimum spacing between pushes is 3 cycles, so the registered PIFO full flag is always valid before the next push decision.
- Push is blocked while pifo_pop=1 because the PIFO gives push precedence over pop and would drop the pop.
- Virtual time: on deq_valid, vtime <= vtime + (15 − deq_priority), wrapping mod 2^VT_W.
- deq_valid during CALC: CALC uses the pre-update vtime; both updates commit at the same edge.
- Cost arithmetic: cost zero-extended to VT_W; cost of 0 is forced to 1.
- Tag wrap: all comparisons are modular. Correct provided live tags stay within 2^(VT_W−1) of vtime.
- Rank saturation: start − vtime > 15 gives rank=15, priority_in=0. The finish tag still uses the unsaturated start.
- Reset mid-operation: the in-flight descriptor is discarded, push drops immediately, and tags and vtime clear.

Optional Feature:
- Macro: PIFO_RANKER_STATS_EN.
- Defined: adds outputs stat_push_cnt (16 bits, +1 per push) and stat_sat_cnt (16 bits, +1 per saturated rank).
  - Both counters saturate at 0xFFFF and clear on reset.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package pifo_pkg:
  - RANK_W=4, QUEUE_SIZE=4, RANK_MAX=15.
  - State enum (IDLE, CALC, PUSH).
  - Modular-compare function tag_ge(a,b).
- One sub-module pifo_tag_table:
  - NUM_FLOWS×VT_W finish-tag register file.
  - One combinational read port, one write port, async active-low clear.

Test Plan:
- Reset release; flow0 len=64 → push in cycle t+2 with priority_in=15; finish[0]=4; in_ready low for 2 cycles.
- Then flow0 len=32 → start=4, rank=4, priority_in=11; finish[0]=6.
- deq_valid with deq_priority=11 → vtime=4. Then flow1 len=16 → start=4, rank=0, priority_in=15.
- Hold pifo_full=1 during PUSH for 5 cycles → no push, in_ready=0. Deassert → push in the next cycle with the unchanged priority_in.
- pifo_pop=1 in the PUSH cycle → push deferred one cycle. Separately, five flow2 len=80 packets with no dequeues → starts 0,5,10,15,20; 5th rank saturates, priority_in=0; stat_sat_cnt=1 when PIFO_RANKER_STATS_EN is defined.
- Assert reset during PUSH with pifo_full=1 → push=0 immediately, vtime=0, finish tags=0. After release, flow0 len=16 → priority_in=15.
